paralelo_serial: RTL and testbench
==================================

PARALELO_SERIAL -- requirements
Module: paralelo_serial

Interface
REQ-001 Parameter COM, default 8'hBC: comma/idle symbol sent when no valid byte is loaded.
REQ-002 Parameter MIN_COM, default 4: COM symbols sent in SYNC before ACTIVE is allowed; legal range 1..15.
REQ-003 Parameter IDLE_MAX, default 16: consecutive COM loads in ACTIVE that force a return to SYNC; legal range 1..255.
REQ-004 clk_32f  input  1  single clock, 8x the byte rate of the upstream mux output; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  8  parallel byte from the upstream 4:1 mux.
REQ-007 valid_in  input  1  data_in qualifier; sampled only on load edges.
REQ-008 data_out  output  1  serial bit stream, MSB first, registered.
REQ-009 load  output  1  combinational; high in the cycle before a load edge, so upstream can align byte changes to it.
REQ-010 active  output  1  registered; high while the FSM is in ACTIVE.

Function
REQ-011 A 3-bit bit_cnt shall increment every clk_32f edge and wrap 7->0; load = (bit_cnt == 7).
REQ-012 A "load edge" is a rising edge with bit_cnt == 7; on it the 8-bit shift register loads the selected byte, otherwise it shifts left one bit.
REQ-013 data_out <= shreg[7] on every edge; a byte loaded at load edge E drives its bit 7 at E+1 and its bit 0 at E+8 (latency 1 cycle, 8 cycles per byte, no gaps).
REQ-014 The FSM has two states: SYNC (reset state) and ACTIVE.
REQ-015 SYNC, load edge: if com_cnt >= MIN_COM and valid_in=1, load data_in and go to ACTIVE; otherwise load COM and increment com_cnt (saturating at 15).
REQ-016 In SYNC, valid_in=1 with com_cnt < MIN_COM loads COM; the data byte is dropped and no error is flagged.
REQ-017 ACTIVE, load edge, valid_in=1: load data_in and clear idle_cnt.
REQ-018 ACTIVE, load edge, valid_in=0: load COM and increment idle_cnt; if idle_cnt reaches IDLE_MAX on this edge, go to SYNC with com_cnt=1 and idle_cnt=0.
REQ-019 active shall follow the FSM state: it rises at the edge that enters ACTIVE and falls at the edge that leaves it.
REQ-020 data_in and valid_in changes on non-load edges shall have no effect.

Reset
REQ-021 While reset=0: bit_cnt=0, shreg=COM, state=SYNC, com_cnt=1 (the preloaded COM counts), idle_cnt=0, data_out=0, active=0, load=0.
REQ-022 Assertion mid-byte or mid-ACTIVE shall take effect immediately, with no clock needed; the partial byte is abandoned.
REQ-023 After release, edges 1..8 shall emit the preloaded COM (bits 7..0), and edge 8 shall be the first load edge.

Structure
REQ-024 COM default, FSM state encodings and counter widths shall live in the shared PHY include file used by the mux and serializer stages.
REQ-025 Single module, no sub-module; FSM, counters and shift register are all inline.

Verification
REQ-026 Release reset with valid_in=1 and data_in=8'hA5 held: data_out shall be BC,BC,BC,BC then A5 repeating (MSB first); active rises at edge 32 and first A5 bit 7 appears at edge 33.
REQ-027 In ACTIVE, apply bytes 00,FF,3C,C3 at successive load pulses: the serial stream matches bit-exact, each byte 8 cycles, no gaps.
REQ-028 In ACTIVE, hold valid_in=0 for 16 load edges: 16 COMs are sent and active falls at the 16th load edge; with valid_in=1 afterwards, 3 more COMs follow (com_cnt restarts at 1), then data.
REQ-029 In ACTIVE, hold valid_in=0 for 15 load edges then 1 for one: active stays high throughout and idle_cnt clears.
REQ-030 Assert reset at bit_cnt=3 of a data byte: data_out=0 and active=0 immediately; after release the REQ-023 sequence repeats exactly.
REQ-031 Toggle data_in/valid_in only on non-load edges: the output stream is unchanged.

Source files
------------

// File: rtl/paralelo_serial_pkg.sv
// Shared PHY definitions for the mux and serializer stages: the comma symbol,
// FSM state encodings, counter widths and a saturating counter helper.
package paralelo_serial_pkg;

  // Comma/idle symbol sent whenever no valid byte is loaded.
  localparam logic [7:0] COM_DEFAULT = 8'hBC;

  // Counter widths.
  localparam int BIT_CNT_W  = 3;  // bit position inside the current byte
  localparam int COM_CNT_W  = 4;  // COM symbols sent while in SYNC
  localparam int IDLE_CNT_W = 8;  // consecutive COM loads while in ACTIVE

  // FSM state encodings.
  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [COM_CNT_W-1:0] COM_CNT_MAX = '1;

  // Increment the COM counter, holding it at its maximum value.
  function automatic logic [COM_CNT_W-1:0] com_cnt_inc(input logic [COM_CNT_W-1:0] c);
    return (c == COM_CNT_MAX) ? c : c + COM_CNT_W'(1);
  endfunction

endpackage

// File: rtl/paralelo_serial.sv
// Parallel-to-serial stage. A byte is loaded every 8 clk_32f edges and sent
// MSB first. After reset the link sends COM symbols (SYNC) until enough of them
// have gone out. Once that happens, valid bytes are forwarded (ACTIVE). A long
// run of idle loads in ACTIVE sends the link back to SYNC.
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter logic [7:0]  COM      = COM_DEFAULT,
  parameter int unsigned MIN_COM  = 4,   // legal range 1..15
  parameter int unsigned IDLE_MAX = 16   // legal range 1..255
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       load,
  output logic       active
);

  localparam logic [COM_CNT_W-1:0]  MIN_COM_C  = COM_CNT_W'(MIN_COM);
  localparam logic [IDLE_CNT_W-1:0] IDLE_MAX_C = IDLE_CNT_W'(IDLE_MAX);

  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [7:0]            shreg;
  logic [0:0]            state;
  logic [COM_CNT_W-1:0]  com_cnt;
  logic [IDLE_CNT_W-1:0] idle_cnt;

  // Load-edge outcome, computed every cycle and applied only when load is high.
  logic [0:0]            state_nxt;
  logic [COM_CNT_W-1:0]  com_nxt;
  logic [IDLE_CNT_W-1:0] idle_nxt;
  logic [IDLE_CNT_W-1:0] idle_inc;
  logic [7:0]            byte_sel;

  // The next edge is a load edge when the bit counter sits on its last bit.
  assign load     = (bit_cnt == '1);
  assign idle_inc = idle_cnt + IDLE_CNT_W'(1);

  // Choose the byte to load and the FSM/counter update for the next load edge.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can leave
    // one unassigned and infer a latch.
    state_nxt = state;
    com_nxt   = com_cnt;
    idle_nxt  = idle_cnt;
    byte_sel  = COM;
    if (state == ST_SYNC) begin
      if (com_cnt >= MIN_COM_C && valid_in) begin
        byte_sel  = data_in;
        state_nxt = ST_ACTIVE;
      end else begin
        // A valid byte offered before enough commas have gone out is dropped.
        com_nxt = com_cnt_inc(com_cnt);
      end
    end else begin
      if (valid_in) begin
        byte_sel = data_in;
        idle_nxt = '0;
      end else if (idle_inc == IDLE_MAX_C) begin
        // The COM loaded on this edge is the first one of the new SYNC run.
        state_nxt = ST_SYNC;
        com_nxt   = COM_CNT_W'(1);
        idle_nxt  = '0;
      end else begin
        idle_nxt = idle_inc;
      end
    end
  end

  // Free-running bit counter, shift register and registered serial output.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      // NOTE: the shift register is reset to COM and not left unreset. That
      // preload is the first symbol on the line after release.
      shreg    <= COM;
      data_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so data_out takes the old shreg[7]
      // while shreg shifts or reloads on the same edge.
      bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      data_out <= shreg[7];
      if (load) begin
        shreg <= byte_sel;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

  // FSM state, COM/idle counters and the active flag, advanced on load edges only.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state    <= ST_SYNC;
      com_cnt  <= COM_CNT_W'(1);  // the preloaded COM counts as the first one
      idle_cnt <= '0;
      active   <= 1'b0;
    end else if (load) begin
      state    <= state_nxt;
      com_cnt  <= com_nxt;
      idle_cnt <= idle_nxt;
      active   <= (state_nxt == ST_ACTIVE);
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench for paralelo_serial. The model works per byte slot: it
// keeps a queue of the bits still due on the line and the link mode. It also
// keeps plain integer counts of commas and idle slots.
module tb_paralelo_serial;

  localparam logic [7:0] COM_B    = 8'hBC;
  localparam int         MIN_COM  = 4;
  localparam int         IDLE_MAX = 16;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out;
  logic       load;
  logic       active;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit exp_q[$];
  bit m_active;
  int m_com;
  int m_idle;
  int ecount;   // clock edges since reset release

  paralelo_serial #(
    .COM      (COM_B),
    .MIN_COM  (MIN_COM),
    .IDLE_MAX (IDLE_MAX)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .load     (load),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  function automatic void push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    push_byte(COM_B);
    m_active = 1'b0;
    m_com    = 1;
    m_idle   = 0;
    ecount   = 0;
  endfunction

  // One clock edge of the link: return the bit due on the line after this edge.
  // On a load edge, also queue the byte chosen by the link rules.
  function automatic bit model_edge(input bit lod, input logic v, input logic [7:0] d);
    bit o;
    o = exp_q.pop_front();
    if (lod) begin
      if (!m_active) begin
        if (m_com >= MIN_COM && v) begin
          push_byte(d);
          m_active = 1'b1;
        end else begin
          push_byte(COM_B);
          if (m_com < 15) m_com++;
        end
      end else if (v) begin
        push_byte(d);
        m_idle = 0;
      end else begin
        push_byte(COM_B);
        m_idle++;
        if (m_idle == IDLE_MAX) begin
          m_active = 1'b0;
          m_com    = 1;
          m_idle   = 0;
        end
      end
    end
    return o;
  endfunction

  // One clock edge. Inputs v/d are applied only if this is a load edge. On
  // other edges the inputs are randomised, and those values must have no effect.
  task automatic tick(input logic v, input logic [7:0] d);
    bit lod;
    bit exp_bit;
    lod = ((ecount + 1) % 8 == 0);
    @(negedge clk_32f);
    total++;
    if (load !== lod) begin
      bad++;
      $display("FAIL load edge=%0d got=%b want=%b", ecount + 1, load, lod);
    end
    if (lod) begin
      valid_in = v;
      data_in  = d;
    end else begin
      valid_in = 1'($urandom_range(0, 1));
      data_in  = 8'($urandom);
    end
    @(posedge clk_32f);
    ecount++;
    exp_bit = model_edge(lod, valid_in, data_in);
    #1;
    total++;
    if (data_out !== exp_bit) begin
      bad++;
      $display("FAIL data_out edge=%0d got=%b want=%b", ecount, data_out, exp_bit);
    end
    total++;
    if (active !== m_active) begin
      bad++;
      $display("FAIL active edge=%0d got=%b want=%b", ecount, active, m_active);
    end
  endtask

  task automatic slot(input logic v, input logic [7:0] d);
    repeat (8) tick(v, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (data_out !== 1'b0 || active !== 1'b0 || load !== 1'b0) begin
      bad++;
      $display("FAIL %s got data_out=%b active=%b load=%b want 0 0 0", tag, data_out, active, load);
    end
  endtask

  // Assert reset away from any edge, hold it over a few edges, then release it
  // in the high phase, so that the next rising edge is edge 1.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk_32f);
    #1 check_reset_outputs("reset_held");
    @(posedge clk_32f);
    #2 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #3 check_reset_outputs("reset_initial");
    do_reset();
  endtask

  // A5 held valid from release: four COMs, active at edge 32, A5 from edge 33.
  task automatic test_startup();
    int rise_edge;
    int first_bit_edge;
    rise_edge = 0;
    first_bit_edge = 0;
    do_reset();
    for (int i = 0; i < 48; i++) begin
      tick(1'b1, 8'hA5);
      if (active === 1'b1 && rise_edge == 0) rise_edge = ecount;
      if (ecount == 33) first_bit_edge = int'(data_out);
    end
    total++;
    if (rise_edge != 32) begin
      bad++;
      $display("FAIL startup_active_rise got=%0d want=32", rise_edge);
    end
    total++;
    if (first_bit_edge != 1) begin
      bad++;
      $display("FAIL startup_first_a5_bit got=%0d want=1", first_bit_edge);
    end
  endtask

  // Back-to-back data bytes with no gaps, including all-zero and all-one bytes.
  task automatic test_patterns();
    logic [7:0] pats [4];
    pats = '{8'h00, 8'hFF, 8'h3C, 8'hC3};
    for (int i = 0; i < 4; i++) slot(1'b1, pats[i]);
    for (int i = 0; i < 8; i++) slot(1'b1, 8'($urandom));
  endtask

  // Sixteen idle load edges drop the link to SYNC. Three COMs must then follow before data resumes.
  task automatic test_idle_exit();
    for (int i = 1; i <= IDLE_MAX; i++) begin
      slot(1'b0, 8'($urandom));
      total++;
      if (active !== (i < IDLE_MAX)) begin
        bad++;
        $display("FAIL idle_exit_active idle=%0d got=%b want=%b", i, active, (i < IDLE_MAX));
      end
    end
    for (int i = 0; i < 6; i++) slot(1'b1, 8'($urandom));
  endtask

  // Fifteen idle slots, then one valid slot, keep the link up. A second run of 15 idle slots keeps it up too.
  task automatic test_idle_15();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < IDLE_MAX - 1; i++) slot(1'b0, 8'h00);
      slot(1'b1, 8'($urandom));
      total++;
      if (active !== 1'b1) begin
        bad++;
        $display("FAIL idle_15_active run=%0d got=%b want=1", r, active);
      end
    end
  endtask

  // Reset three bits into a data byte, then repeat the startup sequence.
  task automatic test_midbyte_reset();
    logic [7:0] d;
    d = 8'($urandom);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);  // bit_cnt now 3, data byte on the line
    do_reset();
    for (int i = 0; i < 6; i++) slot(1'b1, d);
  endtask

  // Random valid/data at load edges, with occasional long idle runs.
  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if (i % 20 == 10) begin
        for (int k = 0; k < IDLE_MAX; k++) slot(1'b0, 8'($urandom));
      end else begin
        slot(1'($urandom_range(0, 3) != 0), 8'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_patterns();
    test_idle_exit();
    test_idle_15();
    test_midbyte_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
